// File: rtl/sopc_bus_pkg.sv
// Shared constants for the SOPC data-side bus: FSM encodings, parameter defaults
// and helper widths. Optional feature macro used by the bus: BUS_TIMEOUT_EN.
package sopc_bus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam int DEF_NUM_SLAVES  = 4;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_DEC_BITS    = 4;
  localparam int DEF_TIMEOUT_CYC = 255;

  // Width of the decoded slave index for the default build.
  localparam int IDX_W = DEF_DEC_BITS;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sopc_bus_decoder.sv
// Combinational slave decoder: upper address bits -> slave index, one-hot select
// and a valid flag for indices that map to an existing slave.
module sopc_bus_decoder
  import sopc_bus_pkg::*;
#(
  parameter int NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int DEC_BITS   = DEF_DEC_BITS
) (
  input  logic [DEC_BITS-1:0]   addr_hi,
  output logic [DEC_BITS-1:0]   idx,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  valid
);

  assign idx   = addr_hi;
  assign valid = (int'(addr_hi) < NUM_SLAVES);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (int'(addr_hi) == k) sel[k] = 1'b1;
    end
  end

endmodule

// File: rtl/sopc_data_bus.sv
// Data-side bus between the OpenMIPS data port and NUM_SLAVES memory-mapped slaves.
// Define BUS_TIMEOUT_EN to abort transactions whose slave never acknowledges.
module sopc_data_bus
  import sopc_bus_pkg::*;
#(
  parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEC_BITS    = DEF_DEC_BITS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_ce_i,
  input  logic                         m_we_i,
  input  logic [ADDR_W-1:0]            m_addr_i,
  input  logic [DATA_W/8-1:0]          m_sel_i,
  input  logic [DATA_W-1:0]            m_data_i,
  output logic [DATA_W-1:0]            m_data_o,
  output logic                         m_stall_o,
  output logic                         m_err_o,
  output logic [NUM_SLAVES-1:0]        s_ce_o,
  output logic                         s_we_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W/8-1:0]          s_sel_o,
  output logic [DATA_W-1:0]            s_data_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]        s_ack_i
);

  logic [1:0]            state_q, state_d;
  logic [DEC_BITS-1:0]   dec_idx, idx_q;
  logic [NUM_SLAVES-1:0] dec_sel, sel_q;
  logic                  dec_valid;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W/8-1:0]   bsel_q;
  logic [DATA_W-1:0]     wdata_q, rdata_q, rdata_mux;
  logic                  ack_hit;
  logic                  capture;

  sopc_bus_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .DEC_BITS   (DEC_BITS)
  ) u_decoder (
    .addr_hi (m_addr_i[ADDR_W-1 -: DEC_BITS]),
    .idx     (dec_idx),
    .sel     (dec_sel),
    .valid   (dec_valid)
  );

  // Only the selected slave's ack counts; stray acks from others are masked.
  assign ack_hit   = |(s_ack_i & sel_q);
  assign rdata_mux = s_data_i[int'(idx_q)*DATA_W +: DATA_W];
  assign capture   = (state_q == ST_IDLE) && m_ce_i;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || state_q != ST_BUSY) tmo_cnt_q <= '0;
    else                           tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (m_ce_i) state_d = dec_valid ? ST_BUSY : ST_ERR;
      ST_BUSY: begin
        if (ack_hit) state_d = ST_RESP;
`ifdef BUS_TIMEOUT_EN
        else if (tmo_hit) state_d = ST_ERR;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      bsel_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        idx_q   <= dec_idx;
        sel_q   <= dec_sel;
        we_q    <= m_we_i;
        addr_q  <= m_addr_i;
        bsel_q  <= m_sel_i;
        wdata_q <= m_data_i;
      end
      if (state_q == ST_BUSY && ack_hit) rdata_q <= we_q ? '0 : rdata_mux;
    end
  end

  // Stall is held low while reset is applied so the CPU sees a quiet bus.
  assign m_stall_o = !rst && (capture || state_q == ST_BUSY);
  assign m_err_o   = (state_q == ST_ERR);
  assign m_data_o  = (state_q == ST_RESP) ? rdata_q : '0;
  assign s_ce_o    = (state_q == ST_BUSY) ? sel_q : '0;
  assign s_we_o    = we_q;
  assign s_addr_o  = addr_q;
  assign s_sel_o   = bsel_q;
  assign s_data_o  = wdata_q;

endmodule

// File: tb/tb_sopc_data_bus.sv
// Scoreboard bench for sopc_data_bus: one task per scenario, expected responses
// queued at issue time and compared when the bus returns RESP or ERR.
module tb_sopc_data_bus;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } resp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             m_ce_i, m_we_i;
  logic [AW-1:0]    m_addr_i;
  logic [DW/8-1:0]  m_sel_i;
  logic [DW-1:0]    m_data_i, m_data_o;
  logic             m_stall_o, m_err_o;
  logic [NS-1:0]    s_ce_o, s_ack_i;
  logic             s_we_o;
  logic [AW-1:0]    s_addr_o;
  logic [DW/8-1:0]  s_sel_o;
  logic [DW-1:0]    s_data_o;
  logic [NS*DW-1:0] s_data_i;

  resp_t exp_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  always #5 clk = ~clk;

  sopc_data_bus #(
    .NUM_SLAVES  (NS),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .DEC_BITS    (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_ce_i    (m_ce_i),
    .m_we_i    (m_we_i),
    .m_addr_i  (m_addr_i),
    .m_sel_i   (m_sel_i),
    .m_data_i  (m_data_i),
    .m_data_o  (m_data_o),
    .m_stall_o (m_stall_o),
    .m_err_o   (m_err_o),
    .s_ce_o    (s_ce_o),
    .s_we_o    (s_we_o),
    .s_addr_o  (s_addr_o),
    .s_sel_o   (s_sel_o),
    .s_data_o  (s_data_o),
    .s_data_i  (s_data_i),
    .s_ack_i   (s_ack_i)
  );

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [3:0] sel,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] exp_data, input logic exp_err);
    resp_t r;
    m_ce_i   = 1'b1;
    m_we_i   = we;
    m_addr_i = addr;
    m_sel_i  = sel;
    m_data_i = wdata;
    r.data   = exp_data;
    r.err    = exp_err;
    exp_q.push_back(r);
  endtask

  task automatic pop_compare(input string name);
    resp_t r;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: response with empty scoreboard, data=%h err=%b", name, m_data_o, m_err_o);
    end else begin
      r = exp_q.pop_front();
      if (m_data_o !== r.data || m_err_o !== r.err)
        $display("FAIL %s: got data=%h err=%b, want data=%h err=%b", name, m_data_o, m_err_o, r.data, r.err);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ce_i = 1'b0; m_we_i = 1'b0; m_addr_i = '0; m_sel_i = '0; m_data_i = '0;
    s_ack_i = '0; s_data_i = '0;
    step(); step();
    sample();
    n_total++;
    if ({m_stall_o, m_err_o, s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o, m_data_o} !== '0)
      $display("FAIL reset_outputs: stall=%b err=%b ce=%b we=%b addr=%h data=%h", m_stall_o, m_err_o, s_ce_o, s_we_o, s_addr_o, m_data_o);
    else n_pass++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_load_zero_wait();
    s_data_i[1*DW +: DW] = 32'hDEAD_BEEF;
    issue(1'b0, 32'h1000_0010, 4'hF, '0, 32'hDEAD_BEEF, 1'b0);
    sample();
    n_total++;
    if (m_stall_o !== 1'b1 || s_ce_o !== 4'b0000) $display("FAIL load_c0: stall=%b ce=%b, want 1 0000", m_stall_o, s_ce_o);
    else n_pass++;
    step(); s_ack_i = 4'b0010;
    sample();
    n_total++;
    if (m_stall_o !== 1'b1 || s_ce_o !== 4'b0010 || s_addr_o !== 32'h1000_0010)
      $display("FAIL load_c1: stall=%b ce=%b addr=%h, want 1 0010 10000010", m_stall_o, s_ce_o, s_addr_o);
    else n_pass++;
    step(); s_ack_i = '0;
    sample();
    n_total++;
    if (m_stall_o !== 1'b0 || s_ce_o !== 4'b0000) $display("FAIL load_c2: stall=%b ce=%b, want 0 0000", m_stall_o, s_ce_o);
    else n_pass++;
    pop_compare("load_resp");
    step(); m_ce_i = 1'b0;
    sample();
    n_total++;
    if (m_data_o !== '0 || m_stall_o !== 1'b0) $display("FAIL load_idle: data=%h stall=%b, want 0 0", m_data_o, m_stall_o);
    else n_pass++;
  endtask

  task automatic test_store_wait();
    s_data_i[0*DW +: DW] = 32'hCAFE_F00D;
    issue(1'b1, 32'h0000_0004, 4'b0011, 32'h1234_5678, '0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      step();
      s_ack_i = (c == 3) ? 4'b0001 : (c == 2) ? 4'b0100 : 4'b0000;
      sample();
      n_total++;
      if (m_stall_o !== 1'b1 || s_ce_o !== 4'b0001 || s_we_o !== 1'b1 || s_sel_o !== 4'b0011 ||
          s_data_o !== 32'h1234_5678 || s_addr_o !== 32'h0000_0004)
        $display("FAIL store_busy%0d: stall=%b ce=%b we=%b sel=%b data=%h, want 1 0001 1 0011 12345678",
                 c, m_stall_o, s_ce_o, s_we_o, s_sel_o, s_data_o);
      else n_pass++;
    end
    step(); s_ack_i = '0;
    sample();
    n_total++;
    if (m_stall_o !== 1'b0 || s_ce_o !== 4'b0000) $display("FAIL store_c4: stall=%b ce=%b, want 0 0000", m_stall_o, s_ce_o);
    else n_pass++;
    pop_compare("store_resp");
    step(); m_ce_i = 1'b0;
  endtask

  task automatic test_unmapped();
    s_data_i = {4{32'hA5A5_A5A5}};
    issue(1'b0, 32'h5000_0000, 4'hF, '0, '0, 1'b1);
    sample();
    n_total++;
    if (m_stall_o !== 1'b1) $display("FAIL unmapped_c0: stall=%b, want 1", m_stall_o);
    else n_pass++;
    step(); s_ack_i = 4'b1111;
    sample();
    n_total++;
    if (m_stall_o !== 1'b0 || s_ce_o !== 4'b0000) $display("FAIL unmapped_c1: stall=%b ce=%b, want 0 0000", m_stall_o, s_ce_o);
    else n_pass++;
    pop_compare("unmapped_err");
    step(); m_ce_i = 1'b0; s_ack_i = '0;
    sample();
    n_total++;
    if (m_err_o !== 1'b0 || s_ce_o !== 4'b0000) $display("FAIL unmapped_c2: err=%b ce=%b, want 0 0000", m_err_o, s_ce_o);
    else n_pass++;
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    for (int run = 0; run < 2; run++) begin
      s_data_i[2*DW +: DW] = 32'h0BAD_0002 + run;
      if (run == 0) issue(1'b0, 32'h2000_0000, 4'hF, '0, '0, 1'b1);
      else          issue(1'b0, 32'h2000_0000, 4'hF, '0, 32'h0BAD_0003, 1'b0);
      for (int c = 1; c <= 8; c++) begin
        step();
        s_ack_i = (run == 1 && c == 8) ? 4'b0100 : 4'b0000;
        sample();
        n_total++;
        if (m_stall_o !== 1'b1 || s_ce_o !== 4'b0100 || m_err_o !== 1'b0)
          $display("FAIL timeout%0d_busy%0d: stall=%b ce=%b err=%b, want 1 0100 0", run, c, m_stall_o, s_ce_o, m_err_o);
        else n_pass++;
      end
      step(); s_ack_i = '0;
      sample();
      n_total++;
      if (m_stall_o !== 1'b0 || s_ce_o !== 4'b0000) $display("FAIL timeout%0d_end: stall=%b ce=%b, want 0 0000", run, m_stall_o, s_ce_o);
      else n_pass++;
      pop_compare("timeout_resp");
      step(); m_ce_i = 1'b0;
    end
  endtask
`else
  task automatic test_timeout();
    s_data_i[2*DW +: DW] = 32'h0BAD_0002;
    issue(1'b0, 32'h2000_0000, 4'hF, '0, 32'h0BAD_0002, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      step();
      s_ack_i = (c == 20) ? 4'b0100 : 4'b0000;
      if (c == 9 || c == 20) begin
        sample();
        n_total++;
        if (m_stall_o !== 1'b1 || s_ce_o !== 4'b0100 || m_err_o !== 1'b0)
          $display("FAIL longwait_busy%0d: stall=%b ce=%b err=%b, want 1 0100 0", c, m_stall_o, s_ce_o, m_err_o);
        else n_pass++;
      end
    end
    step(); s_ack_i = '0;
    sample();
    pop_compare("longwait_resp");
    step(); m_ce_i = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    resp_t dropped;
    s_data_i[1*DW +: DW] = 32'h1111_1111;
    issue(1'b1, 32'h1000_0020, 4'hF, 32'h7777_7777, '0, 1'b0);
    step();
    step(); rst = 1'b1; m_ce_i = 1'b0;
    dropped = exp_q.pop_back();
    step(); rst = 1'b0; s_ack_i = 4'b0010;
    sample();
    n_total++;
    if (s_ce_o !== 4'b0000 || m_stall_o !== 1'b0 || s_addr_o !== '0 || s_we_o !== 1'b0 || s_data_o !== '0)
      $display("FAIL rstmid_after: ce=%b stall=%b addr=%h we=%b wdata=%h, want all 0", s_ce_o, m_stall_o, s_addr_o, s_we_o, s_data_o);
    else n_pass++;
    step(); s_ack_i = '0;
    sample();
    n_total++;
    if (m_data_o !== '0 || m_err_o !== 1'b0 || m_stall_o !== 1'b0)
      $display("FAIL rstmid_late_ack: data=%h err=%b stall=%b, want 0 0 0 (dropped %h)", m_data_o, m_err_o, m_stall_o, dropped.data);
    else n_pass++;
    s_data_i[3*DW +: DW] = 32'h3333_AAAA;
    issue(1'b0, 32'h3000_0000, 4'hF, '0, 32'h3333_AAAA, 1'b0);
    step(); s_ack_i = 4'b1000;
    step(); s_ack_i = '0;
    sample();
    pop_compare("rstmid_new_access");
    step(); m_ce_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    s_data_i[0*DW +: DW] = 32'h0000_00A0;
    s_data_i[3*DW +: DW] = 32'h0000_00D3;
    issue(1'b0, 32'h0000_0000, 4'hF, '0, 32'h0000_00A0, 1'b0);
    step(); s_ack_i = 4'b0001;
    step(); s_ack_i = '0;
    sample();
    pop_compare("b2b_first");
    step();
    issue(1'b0, 32'h3000_0008, 4'hF, '0, 32'h0000_00D3, 1'b0);
    sample();
    n_total++;
    if (m_stall_o !== 1'b1 || s_ce_o !== 4'b0000) $display("FAIL b2b_idle: stall=%b ce=%b, want 1 0000", m_stall_o, s_ce_o);
    else n_pass++;
    step(); s_ack_i = 4'b1000;
    sample();
    n_total++;
    if (s_ce_o !== 4'b1000 || s_addr_o !== 32'h3000_0008) $display("FAIL b2b_busy: ce=%b addr=%h, want 1000 30000008", s_ce_o, s_addr_o);
    else n_pass++;
    step(); s_ack_i = '0;
    sample();
    pop_compare("b2b_second");
    step(); m_ce_i = 1'b0;
    sample();
    n_total++;
    if (exp_q.size() != 0 || m_stall_o !== 1'b0) $display("FAIL b2b_drain: pending=%0d stall=%b, want 0 0", exp_q.size(), m_stall_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_zero_wait();
    test_store_wait();
    test_unmapped();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
